// File: rtl/pio_arb_pkg.sv
// Shared definitions for the two-master PIO arbiter: FSM states,
// master index constants and the PIO data width.
package pio_arb_pkg;

    localparam int DATA_W = 32;

    // Master indices double as the one-bit grant encoding.
    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pio_arb_pick.sv
// Combinational two-way picker: round-robin or fixed priority (m0 first).
import pio_arb_pkg::*;

module pio_arb_pick #(
    parameter bit RR = 1'b1
) (
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic       grant_o
);

    // Choose the winner; on contention RR alternates away from the last grant.
    always_comb begin
        grant_o = M0;
        if (req_i == 2'b11) begin
            grant_o = RR ? ~last_grant_i : M0;
        end else if (req_i[1]) begin
            grant_o = M1;
        end else begin
            grant_o = M0;
        end
    end

endmodule

// File: rtl/pio_arbiter.sv
// Shares the single PIO Avalon-MM slave between the Nios II data master (m0)
// and a hardware requester (m1). One access is captured in IDLE, issued as a
// registered one-cycle strobe in ISSUE, and read data returns the cycle after.
import pio_arb_pkg::*;

module pio_arbiter #(
    parameter bit RR = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_address_i,
    input  logic              m0_read_i,
    input  logic              m0_write_i,
    input  logic [DATA_W-1:0] m0_writedata_i,
    output logic              m0_waitrequest_o,
    output logic [DATA_W-1:0] m0_readdata_o,
    output logic              m0_readdatavalid_o,
    input  logic              m1_address_i,
    input  logic              m1_read_i,
    input  logic              m1_write_i,
    input  logic [DATA_W-1:0] m1_writedata_i,
    output logic              m1_waitrequest_o,
    output logic [DATA_W-1:0] m1_readdata_o,
    output logic              m1_readdatavalid_o,
    output logic              s_address_o,
    output logic              s_read_o,
    output logic              s_write_o,
    output logic [DATA_W-1:0] s_writedata_o,
    input  logic [DATA_W-1:0] s_readdata_i
);

    arb_state_e        state_q, state_d;
    logic              grant_q, grant_d;
    logic              lastGrant_q, lastGrant_d;
    logic              cmdAddr_q, cmdAddr_d;
    logic              cmdRead_q, cmdRead_d;
    logic              cmdWrite_q, cmdWrite_d;
    logic [DATA_W-1:0] cmdWdata_q, cmdWdata_d;
    logic              rdValid_q, rdValid_d;
    logic              rdMaster_q, rdMaster_d;
    logic [DATA_W-1:0] m0Rdata_q, m0Rdata_d;
    logic [DATA_W-1:0] m1Rdata_q, m1Rdata_d;

    logic [1:0]        req;
    logic              pickGrant;
    logic              winAddr;
    logic              winRead;
    logic              winWrite;
    logic [DATA_W-1:0] winWdata;
    logic              issuing;

    assign req = {m1_read_i | m1_write_i, m0_read_i | m0_write_i};

    pio_arb_pick #(
        .RR (RR)
    ) u_pick (
        .req_i        (req),
        .last_grant_i (lastGrant_q),
        .grant_o      (pickGrant)
    );

    // Route the picked master's request fields toward the command register.
    always_comb begin
        winAddr  = m0_address_i;
        winRead  = m0_read_i;
        winWrite = m0_write_i;
        winWdata = m0_writedata_i;
        if (pickGrant == M1) begin
            winAddr  = m1_address_i;
            winRead  = m1_read_i;
            winWrite = m1_write_i;
            winWdata = m1_writedata_i;
        end
    end

    // Next-state logic: capture in IDLE, complete the access and record the grant in ISSUE.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        lastGrant_d = lastGrant_q;
        cmdAddr_d   = cmdAddr_q;
        cmdRead_d   = cmdRead_q;
        cmdWrite_d  = cmdWrite_q;
        cmdWdata_d  = cmdWdata_q;
        rdValid_d   = 1'b0;
        rdMaster_d  = rdMaster_q;
        m0Rdata_d   = m0Rdata_q;
        m1Rdata_d   = m1Rdata_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    // A simultaneous read+write is illegal: the write wins and the read is dropped.
                    cmdAddr_d  = winAddr;
                    cmdRead_d  = winRead & ~winWrite;
                    cmdWrite_d = winWrite;
                    cmdWdata_d = winWdata;
                    grant_d    = pickGrant;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                lastGrant_d = grant_q;
                state_d     = IDLE;
                if (cmdRead_q) begin
                    rdValid_d  = 1'b1;
                    rdMaster_d = grant_q;
                    if (grant_q == M1) begin
                        m1Rdata_d = s_readdata_i;
                    end else begin
                        m0Rdata_d = s_readdata_i;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset parks the arbiter so m0 wins first contention.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= M0;
            lastGrant_q <= M1;
            cmdAddr_q   <= 1'b0;
            cmdRead_q   <= 1'b0;
            cmdWrite_q  <= 1'b0;
            cmdWdata_q  <= '0;
            rdValid_q   <= 1'b0;
            rdMaster_q  <= M0;
            m0Rdata_q   <= '0;
            m1Rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            lastGrant_q <= lastGrant_d;
            cmdAddr_q   <= cmdAddr_d;
            cmdRead_q   <= cmdRead_d;
            cmdWrite_q  <= cmdWrite_d;
            cmdWdata_q  <= cmdWdata_d;
            rdValid_q   <= rdValid_d;
            rdMaster_q  <= rdMaster_d;
            m0Rdata_q   <= m0Rdata_d;
            m1Rdata_q   <= m1Rdata_d;
        end
    end

    // Slave strobes and master handshakes are decoded from registered state only.
    always_comb begin
        issuing            = (state_q == ISSUE);
        s_address_o        = cmdAddr_q;
        s_writedata_o      = cmdWdata_q;
        s_read_o           = issuing & cmdRead_q;
        s_write_o          = issuing & cmdWrite_q;
        m0_waitrequest_o   = ~(issuing & (grant_q == M0));
        m1_waitrequest_o   = ~(issuing & (grant_q == M1));
        m0_readdatavalid_o = rdValid_q & (rdMaster_q == M0);
        m1_readdatavalid_o = rdValid_q & (rdMaster_q == M1);
        m0_readdata_o      = m0Rdata_q;
        m1_readdata_o      = m1Rdata_q;
    end

endmodule
